// File: rtl/ps2_kbd_ascii.sv
// rtl/ps2_kbd_ascii.sv - PS/2 keyboard receiver with set-2 scancode to ASCII translation
module ps2_kbd_ascii #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kbd_data,
  output logic       kbd_int,
  input  logic       kbd_int_ack,
  output logic       kbd_overflow,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          strobe;
  logic          din;

  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid;
  logic          frame_err_q, frame_err_d;

  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic          shift_q, shift_d;
  logic          char_ready_q, char_ready_d;
  logic [7:0]    char_q, char_d;
  logic [8:0]    lookup;
  logic          is_shift_code;

  logic          kbd_int_q, kbd_int_d;
  logic [7:0]    kbd_data_q, kbd_data_d;
  logic          kbd_overflow_q, kbd_overflow_d;

  // Returns {hit, ascii}; letters are stored lowercase and shifted by -0x20 for upper case.
  function automatic logic [8:0] map_code(input logic [7:0] code, input logic upper);
    logic [7:0] letter;
    logic [8:0] res;
    letter = 8'h00;
    res    = 9'h000;
    case (code)
      8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
      8'h45: res = {1'b1, 8'h30};  8'h16: res = {1'b1, 8'h31};
      8'h1E: res = {1'b1, 8'h32};  8'h26: res = {1'b1, 8'h33};
      8'h25: res = {1'b1, 8'h34};  8'h2E: res = {1'b1, 8'h35};
      8'h36: res = {1'b1, 8'h36};  8'h3D: res = {1'b1, 8'h37};
      8'h3E: res = {1'b1, 8'h38};  8'h46: res = {1'b1, 8'h39};
      8'h29: res = {1'b1, 8'h20};  8'h5A: res = {1'b1, 8'h0D};
      8'h66: res = {1'b1, 8'h08};  8'h76: res = {1'b1, 8'h1B};
      default: ;
    endcase
    if (letter != 8'h00) res = {1'b1, upper ? (letter - 8'h20) : letter};
    return res;
  endfunction

  assign din = dat_sync_q[1];

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    filt_d     = filt_q;
    filt_cnt_d = '0;
    strobe     = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
        strobe = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    par_d       = par_q;
    byte_valid  = 1'b0;
    frame_err_d = 1'b0;
    to_cnt_d    = (state_q == IDLE || strobe) ? '0 : to_cnt_q + 1'b1;
    case (state_q)
      IDLE: if (strobe && !din) begin
        state_d   = DATA;
        bit_cnt_d = 3'd0;
      end
      DATA: if (strobe) begin
        sr_d      = {din, sr_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (strobe) begin
        par_d   = din;
        state_d = STOP;
      end
      STOP: if (strobe) begin
        if (din && (^{sr_q, par_q})) byte_valid = 1'b1;
        else                         frame_err_d = 1'b1;
        state_d   = IDLE;
        bit_cnt_d = 3'd0;
      end
      default: state_d = IDLE;
    endcase
    // A stalled partial frame is abandoned silently so the next start bit realigns.
    if (state_q != IDLE && !strobe && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
    end
  end

  assign is_shift_code = (sr_q == 8'h12) || (sr_q == 8'h59);

  always_comb begin
    brk_d        = brk_q;
    ext_d        = ext_q;
    shift_d      = shift_q;
    char_ready_d = 1'b0;
    char_d       = char_q;
    lookup       = map_code(sr_q, shift_q);
    if (byte_valid) begin
      if (sr_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (sr_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q) begin
        if (is_shift_code && !ext_q) shift_d = 1'b0;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (ext_q) begin
        ext_d = 1'b0;
      end else if (is_shift_code) begin
        shift_d = 1'b1;
      end else if (lookup[8]) begin
        char_ready_d = 1'b1;
        char_d       = lookup[7:0];
      end
    end
  end

  always_comb begin
    kbd_int_d      = kbd_int_q;
    kbd_data_d     = kbd_data_q;
    kbd_overflow_d = kbd_overflow_q;
    if (char_ready_q) begin
      if (!kbd_int_q || kbd_int_ack) begin
        kbd_data_d = char_q;
        kbd_int_d  = 1'b1;
        if (kbd_int_q) kbd_overflow_d = 1'b0;
      end else begin
        kbd_overflow_d = 1'b1;
      end
    end else if (kbd_int_q && kbd_int_ack) begin
      kbd_int_d      = 1'b0;
      kbd_overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q     <= 2'b11;
      dat_sync_q     <= 2'b11;
      filt_q         <= 1'b1;
      filt_cnt_q     <= '0;
      state_q        <= IDLE;
      bit_cnt_q      <= 3'd0;
      sr_q           <= 8'h00;
      par_q          <= 1'b0;
      to_cnt_q       <= '0;
      frame_err_q    <= 1'b0;
      brk_q          <= 1'b0;
      ext_q          <= 1'b0;
      shift_q        <= 1'b0;
      char_ready_q   <= 1'b0;
      char_q         <= 8'h00;
      kbd_int_q      <= 1'b0;
      kbd_data_q     <= 8'h00;
      kbd_overflow_q <= 1'b0;
    end else begin
      clk_sync_q     <= clk_sync_d;
      dat_sync_q     <= dat_sync_d;
      filt_q         <= filt_d;
      filt_cnt_q     <= filt_cnt_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      sr_q           <= sr_d;
      par_q          <= par_d;
      to_cnt_q       <= to_cnt_d;
      frame_err_q    <= frame_err_d;
      brk_q          <= brk_d;
      ext_q          <= ext_d;
      shift_q        <= shift_d;
      char_ready_q   <= char_ready_d;
      char_q         <= char_d;
      kbd_int_q      <= kbd_int_d;
      kbd_data_q     <= kbd_data_d;
      kbd_overflow_q <= kbd_overflow_d;
    end
  end

  assign kbd_data     = kbd_data_q;
  assign kbd_int      = kbd_int_q;
  assign kbd_overflow = kbd_overflow_q;
  assign frame_err    = frame_err_q;

endmodule
